// File: rtl/sample_block_counter_if.sv
// ---------------------------------------------------------------------------
// sample_block_counter_if
//   Bundle between the sample-valid source / consumer controller (master)
//   and the sample block counter (slave).
//
//   Master -> slave:
//     clear         synchronous soft clear (same effect as reset)
//     cnt_up        one sample accepted this cycle
//     block_len     samples per block, 0 means 2^CNT_WIDTH
//     mode_oneshot  1 = halt after the next completed block
//     ack           consumer acknowledge of block_done
//   Slave -> master:
//     sample_count  samples counted in the current block
//     block_count   completed blocks, modulo 2^BLK_WIDTH
//     block_pulse   1-cycle pulse per completed block
//     block_done    level flag, set on completion, cleared by ack
//     overrun       sticky, a block completed while block_done was pending
//     halted        counter is in the HALT state
// ---------------------------------------------------------------------------
interface sample_block_counter_if #(
    parameter int CNT_WIDTH = 10,
    parameter int BLK_WIDTH = 8
);
    logic                 clear;
    logic                 cnt_up;
    logic [CNT_WIDTH-1:0] block_len;
    logic                 mode_oneshot;
    logic                 ack;
    logic [CNT_WIDTH-1:0] sample_count;
    logic [BLK_WIDTH-1:0] block_count;
    logic                 block_pulse;
    logic                 block_done;
    logic                 overrun;
    logic                 halted;

    modport master (
        output clear, cnt_up, block_len, mode_oneshot, ack,
        input  sample_count, block_count, block_pulse, block_done, overrun, halted
    );

    modport slave (
        input  clear, cnt_up, block_len, mode_oneshot, ack,
        output sample_count, block_count, block_pulse, block_done, overrun, halted
    );
endinterface

// File: rtl/sample_block_counter.sv
// ---------------------------------------------------------------------------
// sample_block_counter
//   Counts sample strobes into blocks of a run-time programmable length and
//   counts completed blocks. Each completion produces a 1-cycle pulse and a
//   level flag held until acknowledged; a completion while the flag is still
//   pending sets a sticky overrun. In one-shot mode the counter halts after
//   one block until reset or clear.
//
//   Ports:
//     clk  system clock, all state updates on rising edge
//     rst  synchronous active-high reset
//     bus  sample_block_counter_if slave modport (see interface header)
//
//   All outputs come straight from registers.
// ---------------------------------------------------------------------------
module sample_block_counter #(
    parameter int CNT_WIDTH = 10,
    parameter int BLK_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    sample_block_counter_if.slave  bus
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t               state_reg,  state_next;
    logic [CNT_WIDTH-1:0] len_reg,    len_next;
    logic [CNT_WIDTH-1:0] sc_reg,     sc_next;
    logic [BLK_WIDTH-1:0] bc_reg,     bc_next;
    logic                 pulse_reg,  pulse_next;
    logic                 done_reg,   done_next;
    logic                 ovr_reg,    ovr_next;

    // Last index of a block. len_reg = 0 wraps to all ones, which yields
    // 2^CNT_WIDTH samples per block without any special casing.
    logic [CNT_WIDTH-1:0] len_m1;
    logic                 complete;

    assign len_m1   = len_reg - CNT_WIDTH'(1);
    assign complete = (state_reg == ST_RUN) && bus.cnt_up && (sc_reg == len_m1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_RUN;
            len_reg   <= bus.block_len;
            sc_reg    <= '0;
            bc_reg    <= '0;
            pulse_reg <= 1'b0;
            done_reg  <= 1'b0;
            ovr_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            len_reg   <= len_next;
            sc_reg    <= sc_next;
            bc_reg    <= bc_next;
            pulse_reg <= pulse_next;
            done_reg  <= done_next;
            ovr_reg   <= ovr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        sc_next    = sc_reg;
        bc_next    = bc_reg;
        pulse_next = 1'b0;
        done_next  = done_reg;
        ovr_next   = ovr_reg;

        if (bus.clear) begin
            // Soft clear mirrors reset; strobe and ack in this cycle are dropped.
            state_next = ST_RUN;
            len_next   = bus.block_len;
            sc_next    = '0;
            bc_next    = '0;
            done_next  = 1'b0;
            ovr_next   = 1'b0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (complete) begin
                        sc_next    = '0;
                        bc_next    = bc_reg + BLK_WIDTH'(1);
                        pulse_next = 1'b1;
                        // New length only takes effect at block boundaries.
                        len_next   = bus.block_len;
                        if (bus.mode_oneshot) begin
                            state_next = ST_HALT;
                        end
                    end else if (bus.cnt_up) begin
                        sc_next = sc_reg + CNT_WIDTH'(1);
                    end
                end
                ST_HALT: begin
                    sc_next  = '0;
                    len_next = bus.block_len;
                end
                default: begin
                    state_next = ST_RUN;
                end
            endcase

            // A completion re-arms the flag even if ack arrives in the same
            // cycle; only an unacknowledged pending flag counts as overrun.
            if (complete) begin
                done_next = 1'b1;
                if (done_reg && !bus.ack) begin
                    ovr_next = 1'b1;
                end
            end else if (bus.ack) begin
                done_next = 1'b0;
            end
        end
    end

    assign bus.sample_count = sc_reg;
    assign bus.block_count  = bc_reg;
    assign bus.block_pulse  = pulse_reg;
    assign bus.block_done   = done_reg;
    assign bus.overrun      = ovr_reg;
    assign bus.halted       = (state_reg == ST_HALT);

endmodule

// File: tb/tb_sample_block_counter.sv
// ---------------------------------------------------------------------------
// tb_sample_block_counter
//   Two instances: a default-width counter (10/8) and a narrow one (3/2) for
//   the wrap boundaries. Stimulus pushes expected snapshots; monitors running
//   on the falling edge pop and compare them. Pulse expectations are consumed
//   only when the DUT raises block_pulse; probe expectations are consumed at
//   the next falling edge after they are pushed.
// ---------------------------------------------------------------------------
module tb_sample_block_counter;

    typedef struct {
        string name;
        int    sc;
        int    bc;
        bit    pulse;
        bit    done;
        bit    ovr;
        bit    halt;
    } snap_t;

    logic clk;
    logic rst_a;
    logic rst_b;

    sample_block_counter_if #(.CNT_WIDTH(10), .BLK_WIDTH(8)) ifa ();
    sample_block_counter_if #(.CNT_WIDTH(3),  .BLK_WIDTH(2)) ifb ();

    sample_block_counter #(.CNT_WIDTH(10), .BLK_WIDTH(8)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ifa)
    );

    sample_block_counter #(.CNT_WIDTH(3), .BLK_WIDTH(2)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    snap_t pulse_qa[$];
    snap_t probe_qa[$];
    snap_t pulse_qb[$];
    snap_t probe_qb[$];

    function automatic snap_t mk(string n, int sc, int bc, bit p, bit d, bit o, bit h);
        snap_t s;
        s.name  = n;
        s.sc    = sc;
        s.bc    = bc;
        s.pulse = p;
        s.done  = d;
        s.ovr   = o;
        s.halt  = h;
        return s;
    endfunction

    function automatic void cmp(string name, string fld, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %0d expected %0d", name, fld, act, exp);
        end
    endfunction

    function automatic void check_snap(string tag, snap_t act, snap_t exp);
        string n;
        n = {tag, ":", exp.name};
        cmp(n, "sample_count", act.sc, exp.sc);
        cmp(n, "block_count",  act.bc, exp.bc);
        cmp(n, "block_pulse",  int'(act.pulse), int'(exp.pulse));
        cmp(n, "block_done",   int'(act.done),  int'(exp.done));
        cmp(n, "overrun",      int'(act.ovr),   int'(exp.ovr));
        cmp(n, "halted",       int'(act.halt),  int'(exp.halt));
        $display("[%0t] %s sc=%0d bc=%0d pulse=%0b done=%0b ovr=%0b halt=%0b",
                 $time, n, act.sc, act.bc, act.pulse, act.done, act.ovr, act.halt);
    endfunction

    // ---------------- monitors ----------------
    snap_t act_a, exp_a, act_b, exp_b;

    always @(negedge clk) begin
        act_a = mk("", int'(ifa.sample_count), int'(ifa.block_count), ifa.block_pulse,
                   ifa.block_done, ifa.overrun, ifa.halted);
        while (probe_qa.size() > 0) begin
            exp_a = probe_qa.pop_front();
            check_snap("A", act_a, exp_a);
        end
        if (ifa.block_pulse) begin
            if (pulse_qa.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL A:unexpected_pulse: got pulse=1 expected pulse=0 (bc=%0d)", act_a.bc);
            end else begin
                exp_a = pulse_qa.pop_front();
                check_snap("A", act_a, exp_a);
            end
        end
    end

    always @(negedge clk) begin
        act_b = mk("", int'(ifb.sample_count), int'(ifb.block_count), ifb.block_pulse,
                   ifb.block_done, ifb.overrun, ifb.halted);
        while (probe_qb.size() > 0) begin
            exp_b = probe_qb.pop_front();
            check_snap("B", act_b, exp_b);
        end
        if (ifb.block_pulse) begin
            if (pulse_qb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL B:unexpected_pulse: got pulse=1 expected pulse=0 (bc=%0d)", act_b.bc);
            end else begin
                exp_b = pulse_qb.pop_front();
                check_snap("B", act_b, exp_b);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic cyc_a(input bit r, input bit c, input bit cu, input bit ak);
        rst_a      = r;
        ifa.clear  = c;
        ifa.cnt_up = cu;
        ifa.ack    = ak;
        @(posedge clk);
        #1;
        rst_a      = 1'b0;
        ifa.clear  = 1'b0;
        ifa.cnt_up = 1'b0;
        ifa.ack    = 1'b0;
    endtask

    task automatic cyc_b(input bit r, input bit c, input bit cu, input bit ak);
        rst_b      = r;
        ifb.clear  = c;
        ifb.cnt_up = cu;
        ifb.ack    = ak;
        @(posedge clk);
        #1;
        rst_b      = 1'b0;
        ifb.clear  = 1'b0;
        ifb.cnt_up = 1'b0;
        ifb.ack    = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.clear = 1'b0; ifa.cnt_up = 1'b0; ifa.ack = 1'b0; ifa.mode_oneshot = 1'b0;
        ifa.block_len = 10'd1000;
        ifb.clear = 1'b0; ifb.cnt_up = 1'b0; ifb.ack = 1'b0; ifb.mode_oneshot = 1'b0;
        ifb.block_len = 3'd1;

        // ---- reset and basic 1000-sample blocks ----
        cyc_a(1, 0, 0, 0);
        probe_qa.push_back(mk("reset", 0, 0, 0, 0, 0, 0));
        cyc_a(1, 0, 0, 0);
        for (int i = 0; i < 999; i++) cyc_a(0, 0, 1, 0);
        probe_qa.push_back(mk("cnt999", 999, 0, 0, 0, 0, 0));
        cyc_a(0, 0, 1, 0);
        pulse_qa.push_back(mk("blk1", 0, 1, 1, 1, 0, 0));
        cyc_a(0, 0, 1, 0);
        probe_qa.push_back(mk("after_blk1", 1, 1, 0, 1, 0, 0));
        for (int i = 0; i < 998; i++) cyc_a(0, 0, 1, 0);
        probe_qa.push_back(mk("cnt999_b2", 999, 1, 0, 1, 0, 0));
        cyc_a(0, 0, 1, 0);
        pulse_qa.push_back(mk("blk2", 0, 2, 1, 1, 1, 0));

        // ---- reset mid-block; strobe during reset is dropped ----
        for (int i = 0; i < 500; i++) cyc_a(0, 0, 1, 0);
        probe_qa.push_back(mk("pre_rst", 500, 2, 0, 1, 1, 0));
        ifa.block_len = 10'd4;
        cyc_a(1, 0, 1, 1);
        probe_qa.push_back(mk("mid_rst", 0, 0, 0, 0, 0, 0));

        // ---- gapped strobes, length change mid-block ----
        cyc_a(0, 0, 1, 0);
        probe_qa.push_back(mk("gap_s1", 1, 0, 0, 0, 0, 0));
        cyc_a(0, 0, 0, 0);
        cyc_a(0, 0, 1, 0);
        probe_qa.push_back(mk("gap_s2", 2, 0, 0, 0, 0, 0));
        ifa.block_len = 10'd3;
        cyc_a(0, 0, 1, 0);
        probe_qa.push_back(mk("gap_s3", 3, 0, 0, 0, 0, 0));
        cyc_a(0, 0, 0, 0);
        cyc_a(0, 0, 1, 0);
        pulse_qa.push_back(mk("gap_blk1", 0, 1, 1, 1, 0, 0));
        cyc_a(0, 0, 0, 1);
        probe_qa.push_back(mk("ack_clr", 0, 1, 0, 0, 0, 0));
        cyc_a(0, 0, 1, 0);
        probe_qa.push_back(mk("len3_s1", 1, 1, 0, 0, 0, 0));
        cyc_a(0, 0, 1, 0);
        probe_qa.push_back(mk("len3_s2", 2, 1, 0, 0, 0, 0));
        cyc_a(0, 0, 1, 0);
        pulse_qa.push_back(mk("gap_blk2", 0, 2, 1, 1, 0, 0));

        // ---- clear with strobe and ack; then overrun ----
        cyc_a(0, 0, 1, 0);
        ifa.block_len = 10'd2;
        cyc_a(0, 1, 1, 1);
        probe_qa.push_back(mk("mid_clear", 0, 0, 0, 0, 0, 0));
        cyc_a(0, 0, 1, 0);
        probe_qa.push_back(mk("ov_s1", 1, 0, 0, 0, 0, 0));
        cyc_a(0, 0, 1, 0);
        pulse_qa.push_back(mk("ov_blk1", 0, 1, 1, 1, 0, 0));
        cyc_a(0, 0, 1, 0);
        cyc_a(0, 0, 1, 0);
        pulse_qa.push_back(mk("ov_blk2", 0, 2, 1, 1, 1, 0));
        cyc_a(0, 0, 0, 0);
        cyc_a(0, 0, 0, 0);
        probe_qa.push_back(mk("ov_sticky", 0, 2, 0, 1, 1, 0));
        cyc_a(0, 0, 0, 1);
        probe_qa.push_back(mk("ov_ack", 0, 2, 0, 0, 1, 0));

        // ---- ack coincident with completion ----
        cyc_a(0, 1, 0, 0);
        probe_qa.push_back(mk("clear2", 0, 0, 0, 0, 0, 0));
        cyc_a(0, 0, 1, 0);
        cyc_a(0, 0, 1, 0);
        pulse_qa.push_back(mk("sa_blk1", 0, 1, 1, 1, 0, 0));
        cyc_a(0, 0, 1, 0);
        cyc_a(0, 0, 1, 1);
        pulse_qa.push_back(mk("same_ack", 0, 2, 1, 1, 0, 0));
        cyc_a(0, 0, 0, 1);
        probe_qa.push_back(mk("ack_only", 0, 2, 0, 0, 0, 0));
        cyc_a(0, 0, 0, 1);
        probe_qa.push_back(mk("ack_idle", 0, 2, 0, 0, 0, 0));

        // ---- one-shot ----
        ifa.block_len = 10'd5;
        ifa.mode_oneshot = 1'b1;
        cyc_a(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc_a(0, 0, 1, 0);
        probe_qa.push_back(mk("os_s4", 4, 0, 0, 0, 0, 0));
        cyc_a(0, 0, 1, 0);
        pulse_qa.push_back(mk("oneshot", 0, 1, 1, 1, 0, 1));
        for (int i = 0; i < 5; i++) cyc_a(0, 0, 1, 0);
        probe_qa.push_back(mk("halt_hold", 0, 1, 0, 1, 0, 1));
        ifa.mode_oneshot = 1'b0;
        cyc_a(0, 1, 0, 0);
        probe_qa.push_back(mk("halt_clear", 0, 0, 0, 0, 0, 0));

        // ---- block_len = 1: completion on every strobe ----
        ifa.block_len = 10'd1;
        cyc_a(0, 1, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            cyc_a(0, 0, 1, 1);
            pulse_qa.push_back(mk($sformatf("len1_%0d", k), 0, k, 1, 1, 0, 0));
        end
        cyc_a(0, 0, 0, 0);
        probe_qa.push_back(mk("len1_idle", 0, 3, 0, 1, 0, 0));

        // ---- narrow instance: block_count wrap, block_len = 0 ----
        cyc_b(1, 0, 0, 0);
        probe_qb.push_back(mk("reset", 0, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 5; k++) begin
            cyc_b(0, 0, 1, 1);
            pulse_qb.push_back(mk($sformatf("bwrap_%0d", k), 0, k % 4, 1, 1, 0, 0));
        end
        ifb.block_len = 3'd0;
        cyc_b(0, 1, 0, 0);
        for (int i = 0; i < 7; i++) cyc_b(0, 0, 1, 0);
        probe_qb.push_back(mk("len0_s7", 7, 0, 0, 0, 0, 0));
        cyc_b(0, 0, 1, 0);
        pulse_qb.push_back(mk("len0_blk", 0, 1, 1, 1, 0, 0));

        // ---- drain and report expected pulses that never appeared ----
        repeat (3) @(posedge clk);
        #1;
        while (pulse_qa.size() > 0) begin
            exp_a = pulse_qa.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL A:%s missing_pulse: got pulse=0 expected pulse=1", exp_a.name);
        end
        while (pulse_qb.size() > 0) begin
            exp_b = pulse_qb.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL B:%s missing_pulse: got pulse=0 expected pulse=1", exp_b.name);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
